// File: rtl/rgb_sequence_monitor.sv
// Receive-side checker for the RGB LED sequencer: decodes BLANK->RED->GREEN->BLUE->BLANK,
// enforces an exact hold length per colour, counts completed sequences and reports violations.
module rgb_sequence_monitor #(
  parameter int COUNTER_MAX       = 10,
  parameter int CYCLE_COUNT_WIDTH = 8
) (
  input  logic                         clk,
  input  logic                         reset_n,
  input  logic                         red,
  input  logic                         green,
  input  logic                         blue,
  input  logic                         clear_err,
  output logic [2:0]                   state,
  output logic                         cycle_done,
  output logic [CYCLE_COUNT_WIDTH-1:0] cycle_count,
  output logic                         error,
  output logic [2:0]                   error_code,
  output logic                         error_flag
);

  localparam int LEN_W = $clog2(COUNTER_MAX + 1);
  localparam logic [LEN_W-1:0] LEN_MAX = LEN_W'(COUNTER_MAX);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_RED    = 3'd1,
    S_GREEN  = 3'd2,
    S_BLUE   = 3'd3,
    S_RESYNC = 3'd4
  } state_t;

  typedef enum logic [1:0] {
    C_BLANK = 2'd0,
    C_RED   = 2'd1,
    C_GREEN = 2'd2,
    C_BLUE  = 2'd3
  } colour_t;

  localparam logic [2:0] ERR_NONE    = 3'd0;
  localparam logic [2:0] ERR_ILLEGAL = 3'd1;
  localparam logic [2:0] ERR_ORDER   = 3'd2;
  localparam logic [2:0] ERR_SHORT   = 3'd3;
  localparam logic [2:0] ERR_LONG    = 3'd4;

  state_t           state_q;
  logic [LEN_W-1:0] len;
  colour_t          col;
  logic             illegal;
  colour_t          cur;
  colour_t          succ;
  logic [2:0]       ev_code;

  assign state = state_q;

  always_comb begin
    col     = C_BLANK;
    illegal = 1'b0;
    case ({red, green, blue})
      3'b000:  col = C_BLANK;
      3'b100:  col = C_RED;
      3'b010:  col = C_GREEN;
      3'b001:  col = C_BLUE;
      default: illegal = 1'b1;
    endcase
  end

  // Colour states share their encoding with the colour code, so the successor is +1 mod 4
  // (BLUE wraps to BLANK).
  always_comb begin
    cur     = colour_t'(state_q[1:0]);
    succ    = colour_t'(state_q[1:0] + 2'd1);
    ev_code = ERR_NONE;
    case (state_q)
      S_IDLE: begin
        if (illegal)                               ev_code = ERR_ILLEGAL;
        else if (col == C_GREEN || col == C_BLUE)  ev_code = ERR_ORDER;
      end
      S_RED, S_GREEN, S_BLUE: begin
        if (illegal)            ev_code = ERR_ILLEGAL;
        else if (col == cur)  begin if (len == LEN_MAX) ev_code = ERR_LONG;  end
        else if (col == succ) begin if (len != LEN_MAX) ev_code = ERR_SHORT; end
        else                    ev_code = ERR_ORDER;
      end
      default: ev_code = ERR_NONE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= S_IDLE;
      len         <= '0;
      cycle_done  <= 1'b0;
      cycle_count <= '0;
      error       <= 1'b0;
      error_code  <= ERR_NONE;
      error_flag  <= 1'b0;
    end else begin
      cycle_done <= 1'b0;
      error      <= 1'b0;
      if (clear_err) begin
        error_flag <= 1'b0;
        error_code <= ERR_NONE;
      end
      // A new error overrides a simultaneous clear.
      if (ev_code != ERR_NONE) begin
        error      <= 1'b1;
        error_code <= ev_code;
        error_flag <= 1'b1;
        state_q    <= S_RESYNC;
        len        <= '0;
      end else begin
        case (state_q)
          S_IDLE: begin
            if (col == C_RED && !illegal) begin
              state_q <= S_RED;
              len     <= LEN_W'(1);
            end
          end
          S_RED, S_GREEN, S_BLUE: begin
            if (col == cur) begin
              len <= len + 1'b1;
            end else if (state_q == S_BLUE) begin
              state_q    <= S_IDLE;
              len        <= '0;
              cycle_done <= 1'b1;
              if (cycle_count != '1) cycle_count <= cycle_count + 1'b1;
            end else begin
              state_q <= state_t'({1'b0, succ});
              len     <= LEN_W'(1);
            end
          end
          S_RESYNC: begin
            if (col == C_BLANK && !illegal) state_q <= S_IDLE;
          end
          default: begin
            state_q <= S_RESYNC;
            len     <= '0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_rgb_sequence_monitor.sv
// Scoreboard bench for rgb_sequence_monitor: directed scenarios followed by randomized colour
// runs, checked against a sequence-level reference model.
module tb_rgb_sequence_monitor;

  localparam int MAX   = 4;
  localparam int CW    = 2;
  localparam int CNT_SAT = (1 << CW) - 1;

  logic          clk;
  logic          reset_n;
  logic          red, green, blue;
  logic          clear_err;
  logic [2:0]    state;
  logic          cycle_done;
  logic [CW-1:0] cycle_count;
  logic          error;
  logic [2:0]    error_code;
  logic          error_flag;

  rgb_sequence_monitor #(.COUNTER_MAX(MAX), .CYCLE_COUNT_WIDTH(CW)) dut (
    .clk(clk), .reset_n(reset_n), .red(red), .green(green), .blue(blue),
    .clear_err(clear_err), .state(state), .cycle_done(cycle_done),
    .cycle_count(cycle_count), .error(error), .error_code(error_code),
    .error_flag(error_flag)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int st; int done; int cnt; int err; int code; int flag;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   n_done_seen = 0;

  // Reference model: which colour is being held, for how long, and whether we are resyncing.
  int m_resync = 0, m_cur = 0, m_run = 0, m_cnt = 0, m_code = 0, m_flag = 0;

  function automatic logic [2:0] colour_rgb(input int c);
    case (c)
      1:       return 3'b100;
      2:       return 3'b010;
      3:       return 3'b001;
      default: return 3'b000;
    endcase
  endfunction

  task automatic model_step(input logic [2:0] rgb, input bit clr, input bit rn, output exp_t e);
    int col, ecode, done;
    bit ill;
    ill = 0; col = 0; ecode = 0; done = 0;
    case (rgb)
      3'b000:  col = 0;
      3'b100:  col = 1;
      3'b010:  col = 2;
      3'b001:  col = 3;
      default: ill = 1;
    endcase
    if (!rn) begin
      m_resync = 0; m_cur = 0; m_run = 0; m_cnt = 0; m_code = 0; m_flag = 0;
      e = '{0, 0, 0, 0, 0, 0};
    end else begin
      if (m_resync != 0) begin
        if (!ill && col == 0) begin m_resync = 0; m_cur = 0; end
      end else if (ill) ecode = 1;
      else if (m_cur == 0) begin
        if (col == 1) begin m_cur = 1; m_run = 1; end
        else if (col != 0) ecode = 2;
      end else if (col == m_cur) begin
        if (m_run == MAX) ecode = 4; else m_run++;
      end else if (col == (m_cur + 1) % 4) begin
        if (m_run < MAX) ecode = 3;
        else begin
          m_cur = col;
          m_run = (col == 0) ? 0 : 1;
          if (col == 0) begin
            done = 1;
            if (m_cnt < CNT_SAT) m_cnt++;
          end
        end
      end else ecode = 2;
      if (clr) begin m_flag = 0; m_code = 0; end
      if (ecode != 0) begin m_resync = 1; m_run = 0; m_code = ecode; m_flag = 1; end
      e = '{(m_resync != 0) ? 4 : m_cur, done, m_cnt, (ecode != 0) ? 1 : 0, m_code, m_flag};
    end
  endtask

  task automatic drive(input logic [2:0] rgb, input bit clr, input bit rn);
    exp_t e;
    @(negedge clk);
    {red, green, blue} = rgb;
    clear_err = clr;
    reset_n   = rn;
    model_step(rgb, clr, rn, e);
    sb.push_back(e);
  endtask

  task automatic hold(input logic [2:0] rgb, input int n);
    for (int i = 0; i < n; i++) drive(rgb, 1'b0, 1'b1);
  endtask

  task automatic legal_seq();
    hold(3'b100, MAX); hold(3'b010, MAX); hold(3'b001, MAX); hold(3'b000, 1);
  endtask

  task automatic chk(input string nm, input logic [7:0] act, input int exp);
    n_checks++;
    if (act !== 8'(exp)) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d at time %0t", nm, act, exp, $time);
    end
  endtask

  // Monitor: outputs are valid every cycle, sampled 1ns after the active edge.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (sb.size() > 0) begin
        e = sb.pop_front();
        chk("state",       8'(state),       e.st);
        chk("cycle_done",  8'(cycle_done),  e.done);
        chk("cycle_count", 8'(cycle_count), e.cnt);
        chk("error",       8'(error),       e.err);
        chk("error_code",  8'(error_code),  e.code);
        chk("error_flag",  8'(error_flag),  e.flag);
        if (cycle_done === 1'b1) n_done_seen++;
      end
    end
  end

  initial begin
    int r, c, n, ill_pick, gen;
    logic [2:0] ill_codes [4];
    ill_codes[0] = 3'b110; ill_codes[1] = 3'b011; ill_codes[2] = 3'b101; ill_codes[3] = 3'b111;
    reset_n = 1'b0; red = 1'b0; green = 1'b0; blue = 1'b0; clear_err = 1'b0;
    gen = 0;

    repeat (3) drive(3'b000, 1'b0, 1'b0);
    // Clean sequence
    hold(3'b000, 2); legal_seq(); hold(3'b000, 1);
    // Reset mid-GREEN
    hold(3'b100, MAX); hold(3'b010, 2);
    drive(3'b010, 1'b0, 1'b0); drive(3'b000, 1'b0, 1'b0); hold(3'b000, 1);
    // SHORT, resync, clear
    hold(3'b100, 3); hold(3'b010, 1); hold(3'b000, 1);
    drive(3'b000, 1'b1, 1'b1); hold(3'b000, 1);
    // LONG, ORDER from RED, ORDER from IDLE
    hold(3'b100, 5); hold(3'b000, 1);
    hold(3'b100, MAX); hold(3'b001, 1); hold(3'b000, 1);
    hold(3'b010, 1); hold(3'b000, 1);
    // ILLEGAL during GREEN, 111 ignored in RESYNC, clear colliding with a new error
    hold(3'b100, MAX); hold(3'b010, 2); hold(3'b110, 1); hold(3'b111, 1);
    hold(3'b000, 1); drive(3'b010, 1'b1, 1'b1); hold(3'b000, 1);
    // Saturation of the completed-sequence counter
    drive(3'b000, 1'b0, 1'b0); hold(3'b000, 1);
    for (int i = 0; i < 5; i++) legal_seq();
    hold(3'b000, 2);

    for (int s = 0; s < 400; s++) begin
      r = $urandom_range(0, 99);
      if (r < 2) begin
        drive(3'b000, 1'b0, 1'b0);
      end else if (r < 8) begin
        ill_pick = $urandom_range(0, 3);
        drive(ill_codes[ill_pick], ($urandom_range(0, 3) == 0), 1'b1);
      end else begin
        c = ($urandom_range(0, 9) < 8) ? gen : $urandom_range(0, 3);
        gen = (c + 1) % 4;
        if (c == 0) n = $urandom_range(1, 2);
        else n = ($urandom_range(0, 3) == 0) ? $urandom_range(MAX - 1, MAX + 1) : MAX;
        for (int k = 0; k < n; k++) drive(colour_rgb(c), ($urandom_range(0, 19) == 0), 1'b1);
      end
    end

    for (int w = 0; w < 10 && sb.size() > 0; w++) @(posedge clk);
    #2;
    chk("scoreboard_drained", 8'(sb.size()), 0);
    n_checks++;
    if (n_done_seen < 6) begin
      n_fail++;
      $display("FAIL done_pulses: got %0d, expected at least 6", n_done_seen);
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
